updated_key_expansion: RTL and testbench

- Sequential AES-256 key-schedule generator for the AES-256-CTR datapath.
- Takes the 256-bit cipher key and streams the 15 round keys (RK0..RK14), 128 bits each, one per clock on out_key.
- Feeds the round pipeline.
- Computes 4 schedule words per cycle from an internal 8-word sliding window.

---
 rtl/updated_key_expansion.sv | 124 ++++++++++++
 tb/tb_updated_key_expansion.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/updated_key_expansion.sv
// updated_key_expansion: AES-256 key schedule that streams RK0..RK14 (128 bits each),
// one round key per clock after reset release, from an 8-word sliding window.
// Build option: define KEYEXP_DONE_EN to add a sticky 'done' output flagging RK14.

// Forward AES S-box, one byte lookup.
module aes_sbox (
  input  logic [7:0] idx,
  output logic [7:0] sub
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub = SBOX[idx];
endmodule

module updated_key_expansion (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key,
  output logic [127:0] out_key
`ifdef KEYEXP_DONE_EN
  ,
  output logic         done
`endif
);
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned RK_W     = 128;
  localparam int unsigned WIN_W    = 256;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CNT_LAST = 15;

  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [WIN_W-1:0]  window, window_nxt;
  logic [7:0]        rcon, rcon_nxt;
  logic [RK_W-1:0]   out_key_nxt;
  logic [WORD_W-1:0] last_word, sub_in, sub_out, temp;
  logic [WORD_W-1:0] nw0, nw1, nw2, nw3;
  logic              even_rk;

  // Even round keys (cnt even) take the RotWord+Rcon rule, odd ones SubWord only.
  assign even_rk   = ~cnt[0];
  assign last_word = window[WORD_W-1:0];
  assign sub_in    = even_rk ? {last_word[23:0], last_word[31:24]} : last_word;

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (
      .idx (sub_in[8*g +: 8]),
      .sub (sub_out[8*g +: 8])
    );
  end

  // New four schedule words, chained by XOR against the oldest window words.
  assign temp = even_rk ? (sub_out ^ {rcon, 24'h0}) : sub_out;
  assign nw0  = window[255:224] ^ temp;
  assign nw1  = window[223:192] ^ nw0;
  assign nw2  = window[191:160] ^ nw1;
  assign nw3  = window[159:128] ^ nw2;

  // Next-state: capture key, emit its halves, then generate RK2..RK14 and hold.
  always_comb begin
    cnt_nxt     = cnt;
    window_nxt  = window;
    rcon_nxt    = rcon;
    out_key_nxt = out_key;
    if (cnt == CNT_W'(0)) begin
      window_nxt  = key;
      out_key_nxt = key[255:128];
      cnt_nxt     = CNT_W'(1);
    end else if (cnt == CNT_W'(1)) begin
      out_key_nxt = window[127:0];
      cnt_nxt     = CNT_W'(2);
    end else if (cnt != CNT_W'(CNT_LAST)) begin
      out_key_nxt = {nw0, nw1, nw2, nw3};
      window_nxt  = {window[127:0], nw0, nw1, nw2, nw3};
      if (even_rk) begin
        rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Schedule registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      window  <= '0;
      rcon    <= 8'h01;
      out_key <= '0;
    end else begin
      cnt     <= cnt_nxt;
      window  <= window_nxt;
      rcon    <= rcon_nxt;
      out_key <= out_key_nxt;
    end
  end

`ifdef KEYEXP_DONE_EN
  // Sticky flag raised on the edge that presents RK14.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else if (cnt == CNT_W'(CNT_LAST - 1)) begin
      done <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_updated_key_expansion.sv
// Bench for updated_key_expansion: known-answer table, full-sequence and reset corner
// cases, and random keys against a FIPS-197 word-level model (honours KEYEXP_DONE_EN).
module tb_updated_key_expansion;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key;
  logic [127:0] out_key;
`ifdef KEYEXP_DONE_EN
  logic         done;
`endif

  updated_key_expansion dut (
    .clk     (clk),
    .rst     (rst),
    .key     (key),
    .out_key (out_key)
`ifdef KEYEXP_DONE_EN
    ,
    .done    (done)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  sbox_m [256];
  logic [31:0] w_m [60];

  localparam logic [255:0] K_PLAN = 256'h642423baa95efb4362d3f2ce993c0904150f258aa1fe796841d7b4429c9b5a30;
  localparam logic [255:0] K_FIPS = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct {
    logic [255:0] key;
    int           edge_n;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from its algebraic definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] a8, inv;
    for (int a = 0; a < 256; a++) begin
      a8  = 8'(a);
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(a8, 8'(b)) == 8'h01) inv = 8'(b);
      end
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  // Full 60-word AES-256 expansion.
  task automatic expand(input logic [255:0] k);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w_m[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w_m[i-1];
      if (i % 8 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w_m[i] = w_m[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] rk(input int r);
    return {w_m[4*r], w_m[4*r+1], w_m[4*r+2], w_m[4*r+3]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_done(input string name, input logic exp);
`ifdef KEYEXP_DONE_EN
    checks++;
    if (done !== exp) begin
      errors++;
      $display("FAIL %s: done got %b expected %b", name, done, exp);
    end
`else
    if (exp === 1'bx) $display("unused %s", name);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset for one cycle with key applied, then release at a falling edge.
  task automatic restart(input logic [255:0] k);
    @(negedge clk);
    rst = 1'b0;
    key = k;
    @(negedge clk);
    check("reset_out", out_key, 128'h0);
    rst = 1'b1;
  endtask

  // Run edges 1..last against the model (model already expanded).
  task automatic run_seq(input string name, input int last);
    for (int n = 1; n <= last; n++) begin
      step();
      check(name, out_key, rk((n - 1 > 14) ? 14 : n - 1));
      check_done(name, n >= 15);
    end
  endtask

  logic [255:0] k1, k2;

  initial begin
    rst = 1'b0;
    key = K_PLAN;
    build_sbox();

    // Reset holds output at zero regardless of clock.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hold", out_key, 128'h0);
      check_done("rst_hold", 1'b0);
    end

    tbl[0] = '{K_PLAN, 1, 128'h642423baa95efb4362d3f2ce993c0904};
    tbl[1] = '{K_PLAN, 2, 128'h150f258aa1fe796841d7b4429c9b5a30};
    tbl[2] = '{K_PLAN, 3, 128'h719a2764d8c4dc27ba172ee9232b27ed};
    tbl[3] = '{K_FIPS, 15, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    tbl[4] = '{256'h0, 3, 128'h62636363626363636263636362636363};
    tbl[5] = '{256'h0, 4, 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb};

    for (int t = 0; t < 6; t++) begin
      restart(tbl[t].key);
      for (int n = 0; n < tbl[t].edge_n; n++) step();
      check($sformatf("kat%0d", t), out_key, tbl[t].exp);
    end

    // FIPS key: full sequence then hold through edge 70.
    expand(K_FIPS);
    restart(K_FIPS);
    run_seq("fips_hold", 70);

    // Key changes after edge 1 are ignored.
    k1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    expand(k1);
    restart(k1);
    step();
    check("chg_rk0", out_key, rk(0));
    key = ~k1;
    step();
    check("chg_rk1", out_key, k1[127:0]);
    for (int n = 3; n <= 16; n++) begin
      step();
      check("chg_seq", out_key, rk((n - 1 > 14) ? 14 : n - 1));
    end

    // Asynchronous reset between edges 6 and 7, then a fresh key sample.
    restart(k1);
    run_seq("pre_async", 6);
    #1 rst = 1'b0;
    #1 check("async_rst", out_key, 128'h0);
    check_done("async_rst", 1'b0);
    k2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    key = k2;
    expand(k2);
    @(negedge clk);
    check("async_hold", out_key, 128'h0);
    rst = 1'b1;
    run_seq("post_async", 16);

    // Random keys against the model.
    for (int r = 0; r < 4; r++) begin
      k1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      expand(k1);
      restart(k1);
      run_seq($sformatf("rand%0d", r), 17);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
